// File: rtl/varint_field_collector_if.sv
// Handshake bundle between the varint output stage, the field collector and
// the record consumer. The collector uses the slave view; whoever drives the
// varints and takes the records uses the master view.
interface varint_field_collector_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int INDEX_WIDTH = 4,
  parameter int NUM_FIELDS  = 8
);

  logic                             varint_data_valid;
  logic [DATA_WIDTH-1:0]            varint_data;
  logic [INDEX_WIDTH-1:0]           varint_index;
  logic                             varint_data_accepted;
  logic                             msg_end;
  logic                             record_valid;
  logic                             record_ready;
  logic [NUM_FIELDS*DATA_WIDTH-1:0] record_data;
  logic [NUM_FIELDS-1:0]            record_present;
  logic                             index_error;
  logic [15:0]                      record_count;

  modport master (
    output varint_data_valid,
    output varint_data,
    output varint_index,
    output msg_end,
    output record_ready,
    input  varint_data_accepted,
    input  record_valid,
    input  record_data,
    input  record_present,
    input  index_error,
    input  record_count
  );

  modport slave (
    input  varint_data_valid,
    input  varint_data,
    input  varint_index,
    input  msg_end,
    input  record_ready,
    output varint_data_accepted,
    output record_valid,
    output record_data,
    output record_present,
    output index_error,
    output record_count
  );

endinterface

// File: rtl/varint_field_collector.sv
// Varint field collector: takes decoded varints tagged with a field index,
// files each one into a per-field register bank, and on end-of-message hands
// the assembled record (values plus presence mask) to the next stage.
// Every output comes straight from a flop, so no input reaches an output
// combinationally.
module varint_field_collector #(
  parameter int DATA_WIDTH  = 64,
  parameter int INDEX_WIDTH = 4,
  parameter int NUM_FIELDS  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  varint_field_collector_if.slave bus
);

  typedef enum logic [2:0] {
    COLLECT = 3'b001,
    ACK     = 3'b010,
    EMIT    = 3'b100
  } state_t;

  state_t                           state;
  logic [DATA_WIDTH-1:0]            held_data;
  logic [INDEX_WIDTH-1:0]           held_index;
  logic                             held_in_range;
  logic                             msg_end_pending;
  logic [NUM_FIELDS*DATA_WIDTH-1:0] field_bank;
  logic [NUM_FIELDS-1:0]            present_bits;
  logic [15:0]                      record_count_q;
  logic                             accepted_q;
  logic                             record_valid_q;
  logic                             index_error_q;
  logic                             index_in_range;

  // Range check of the offered index, evaluated when the value is captured so
  // that ACK only has to look at a single held flag.
  assign index_in_range = ({{(32-INDEX_WIDTH){1'b0}}, bus.varint_index} < NUM_FIELDS);

  // Collector FSM: capture in COLLECT, commit and acknowledge in ACK, hold the
  // record in EMIT until downstream takes it. A msg_end that cannot be served
  // right away is remembered in a single pending flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= COLLECT;
      held_data       <= '0;
      held_index      <= '0;
      held_in_range   <= 1'b0;
      msg_end_pending <= 1'b0;
      field_bank      <= '0;
      present_bits    <= '0;
      record_count_q  <= '0;
      accepted_q      <= 1'b0;
      record_valid_q  <= 1'b0;
      index_error_q   <= 1'b0;
    end else begin
      accepted_q    <= 1'b0;
      index_error_q <= 1'b0;
      unique case (state)
        COLLECT: begin
          if (bus.varint_data_valid) begin
            state         <= ACK;
            held_data     <= bus.varint_data;
            held_index    <= bus.varint_index;
            held_in_range <= index_in_range;
            accepted_q    <= 1'b1;
            index_error_q <= ~index_in_range;
            if (bus.msg_end) begin
              msg_end_pending <= 1'b1;
            end
          end else if (bus.msg_end || msg_end_pending) begin
            state           <= EMIT;
            msg_end_pending <= 1'b0;
            record_valid_q  <= 1'b1;
          end
        end
        ACK: begin
          if (held_in_range) begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
              if (held_index == INDEX_WIDTH'(i)) begin
                field_bank[i*DATA_WIDTH +: DATA_WIDTH] <= held_data;
                present_bits[i]                        <= 1'b1;
              end
            end
          end
          if (bus.msg_end) begin
            msg_end_pending <= 1'b1;
          end
          state <= COLLECT;
        end
        EMIT: begin
          if (bus.msg_end) begin
            msg_end_pending <= 1'b1;
          end
          if (bus.record_ready) begin
            field_bank     <= '0;
            present_bits   <= '0;
            record_count_q <= record_count_q + 16'd1;
            record_valid_q <= 1'b0;
            state          <= COLLECT;
          end
        end
        default: begin
          state          <= COLLECT;
          record_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.varint_data_accepted = accepted_q;
  assign bus.record_valid         = record_valid_q;
  assign bus.record_data          = field_bank;
  assign bus.record_present       = present_bits;
  assign bus.index_error          = index_error_q;
  assign bus.record_count         = record_count_q;

endmodule

// File: doc/varint_field_collector.md
Name: varint_field_collector

Overview:
- Downstream consumer of the varint output stage.
- Accepts decoded varint values with their field index through the `varint_data_valid`/`varint_data_accepted` handshake.
- Stores each value in a per-field register bank and tracks which fields are present.
- On end-of-message, presents the assembled record to the next stage through a valid/ready handshake.

Parameters:
- DATA_WIDTH, 64: width of one decoded varint value.
- INDEX_WIDTH, 4: width of the field index.
- NUM_FIELDS, 8: number of field slots. Legal range is 1..2^INDEX_WIDTH.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- varint_data_valid  in  1  upstream holds high while a value is offered.
- varint_data  in  DATA_WIDTH  decoded value; stable while valid is high.
- varint_index  in  INDEX_WIDTH  field slot for varint_data; stable while valid is high.
- varint_data_accepted  out  1  single-cycle accept pulse to upstream.
- msg_end  in  1  single-cycle pulse marking the end of the current message.
- record_valid  out  1  assembled record offered downstream.
- record_ready  in  1  downstream takes the record when high with record_valid.
- record_data  out  NUM_FIELDS*DATA_WIDTH  field bank; slot i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- record_present  out  NUM_FIELDS  bit i set when slot i was written in this message.
- index_error  out  1  single-cycle pulse when an accepted value has index >= NUM_FIELDS.
- record_count  out  16  number of records handed off; wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset (asynchronous, immediate, including mid-handshake):
  - state = COLLECT.
  - All field registers, record_present, record_count and msg_end_pending = 0.
  - varint_data_accepted, record_valid and index_error = 0.
- State encoding is one-hot: COLLECT, ACK, EMIT. All outputs are registered or decoded from state only; there is no combinational path from any input to any output.
- COLLECT:
  - If varint_data_valid = 1, go to ACK and capture data/index into holding registers.
  - Else, if msg_end = 1 or msg_end_pending = 1, go to EMIT and clear msg_end_pending.
  - Else stay in COLLECT.
- ACK (exactly one cycle):
  - varint_data_accepted = 1.
  - If the held index < NUM_FIELDS: write slot[index] = held data and set record_present[index]. Otherwise there is no write and index_error = 1 for this cycle.
  - Always return to COLLECT.
  - varint_data_valid is still high during ACK (upstream sees accepted in this cycle) and is ignored.
  - Accept-to-accept spacing is at least 2 cycles, so the same datum is never taken twice.
- Accept latency: varint_data_accepted rises exactly 1 cycle after the first cycle varint_data_valid is seen high in COLLECT.
- Duplicate index within one message: last write wins; the present bit stays set.
- EMIT:
  - record_valid = 1. record_data and record_present are held stable.
  - varint_data_accepted stays 0, so upstream is back-pressured.
  - When record_ready = 1:
    - clear all field registers and record_present;
    - record_count += 1 (mod 2^16);
    - go to COLLECT.
  - record_ready while not in EMIT is ignored.
- msg_end pending rules:
  - msg_end in the same cycle as varint_data_valid in COLLECT: the varint is taken first, msg_end_pending is set, and EMIT follows after ACK. The final varint belongs to the ending message.
  - msg_end during ACK or EMIT sets msg_end_pending.
  - A pending msg_end after an EMIT handshake produces the next record, which may be empty (record_present = 0). An empty protobuf message is legal.
  - msg_end while msg_end_pending is already set is merged: a single pending flag, no counter.
- msg_end in COLLECT with no prior fields emits an empty record (all-zero data and present).
- index_error does not abort the message and does not affect record_present.

Test Plan:
- Upstream offers idx=2 data=0x1234, then idx=5 data=0xFFFF_FFFF_FFFF_FFFF, then a msg_end pulse → two accepted pulses, each 1 cycle after valid. Record then shows slot2=0x1234, slot5=all-ones, present=8'b0010_0100. With record_ready=1, record_count goes 0→1 and present clears.
- idx=3 data=7 then idx=3 data=9, then msg_end; record_ready held low for 10 cycles, then high → record_valid high for all 10 cycles with slot3=9 and present=8'b0000_1000 stable. During those cycles a new upstream value gets no accept; it is accepted 1 cycle after return to COLLECT.
- idx=12 (NUM_FIELDS=8) data=0xAB → accepted pulses and index_error pulses in the same cycle. On the following msg_end, present=0 and all slots are 0.
- varint_data_valid with idx=1 data=0x55 and msg_end in the same cycle → value accepted first, then EMIT with present=8'b0000_0010. A second msg_end during EMIT yields a following empty record; record_count advances by 2 in total.
- reset asserted asynchronously mid-ACK and mid-EMIT → accepted, record_valid and index_error drop immediately; present=0 and record_count=0; the state resumes in COLLECT after reset deasserts. Also preload record_count=0xFFFF via 65535 empty records, then one more handshake → 0x0000.
